// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: ALU vs. buffered MDU results, with a starvation guard and MDU scoreboard.
// Optional WB_TRACE_EN prints every register-file write as "wb <alu|mdu> reg <rd> val <wData>".
module regfile_wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        aluValid,
    input  logic [4:0]  aluRd,
    input  logic [31:0] aluData,
    output logic        aluHold,
    input  logic        mduValid,
    input  logic [4:0]  mduRd,
    input  logic [31:0] mduData,
    output logic        mduReady,
    input  logic        issueMdu,
    input  logic [4:0]  issueRd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  idRd,
    output logic        stall,
    output logic [4:0]  rd,
    output logic [31:0] wData,
    output logic        regWr
);

    localparam logic [4:0] STARVE_LIM = 5'(STARVE_MAX);

    logic [4:0]  fifo_rd   [2];
    logic [31:0] fifo_data [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [1:0]  count_nxt;
    logic        fifo_empty;
    logic        fifo_full;

    logic [4:0]  starve_cnt;
    logic [4:0]  starve_nxt;
    logic [31:0] pending;
    logic [31:0] pending_nxt;

    logic        alu_win;
    logic        mdu_win;
    logic        win_any;
    logic        push;
    logic        pop;
    logic [4:0]  head_rd;
    logic [31:0] head_data;
    logic [4:0]  win_rd;
    logic [31:0] win_data;

    always_comb begin
        fifo_empty = (count == 2'd0);
        fifo_full  = (count == 2'd2);
        head_rd    = fifo_rd[rd_ptr];
        head_data  = fifo_data[rd_ptr];

        // Reset forces the handshake/hazard outputs to their idle values regardless of stale state.
        mduReady = rst | ~fifo_full;
        aluHold  = ~rst & ~fifo_empty & (starve_cnt == STARVE_LIM);

        alu_win = aluValid & ~aluHold;
        mdu_win = ~alu_win & ~fifo_empty;
        win_any = alu_win | mdu_win;
        push    = mduValid & mduReady;
        pop     = mdu_win;

        win_rd   = aluRd;
        win_data = aluData;
        if (mdu_win) begin
            win_rd   = head_rd;
            win_data = head_data;
        end

        count_nxt = count + {1'b0, push} - {1'b0, pop};

        starve_nxt = 5'd0;
        if (alu_win && !fifo_empty) begin
            starve_nxt = starve_cnt + 5'd1;
        end

        // Clear before set so an issue to the same register in the retiring cycle stays pending.
        pending_nxt = pending;
        if (mdu_win) begin
            pending_nxt[head_rd] = 1'b0;
        end
        if (issueMdu && (issueRd != 5'd0)) begin
            pending_nxt[issueRd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;

        stall = ~rst & (pending[rs1] | pending[rs2] | pending[idRd]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            starve_cnt <= 5'd0;
            pending    <= 32'd0;
            rd         <= 5'd0;
            wData      <= 32'd0;
            regWr      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count      <= count_nxt;
            starve_cnt <= starve_nxt;
            pending    <= pending_nxt;
            regWr      <= win_any && (win_rd != 5'd0);
            if (win_any) begin
                rd    <= win_rd;
                wData <= win_data;
            end
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_rd[wr_ptr]   <= mduRd;
            fifo_data[wr_ptr] <= mduData;
        end
    end

`ifdef WB_TRACE_EN
    logic wr_src_mdu;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_src_mdu <= 1'b0;
        end else if (win_any) begin
            wr_src_mdu <= mdu_win;
        end
    end

    always_ff @(posedge clk) begin
        if (regWr) begin
            $write("wb %s reg %0d val %08h\n", wr_src_mdu ? "mdu" : "alu", rd, wData);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_regfile_wb_arbiter;

    localparam int SM = 4;

    logic        clk;
    logic        rst;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        aluHold;
    logic        mduValid;
    logic [4:0]  mduRd;
    logic [31:0] mduData;
    logic        mduReady;
    logic        issueMdu;
    logic [4:0]  issueRd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  idRd;
    logic        stall;
    logic [4:0]  rd;
    logic [31:0] wData;
    logic        regWr;

    regfile_wb_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .aluValid(aluValid), .aluRd(aluRd), .aluData(aluData), .aluHold(aluHold),
        .mduValid(mduValid), .mduRd(mduRd), .mduData(mduData), .mduReady(mduReady),
        .issueMdu(issueMdu), .issueRd(issueRd),
        .rs1(rs1), .rs2(rs2), .idRd(idRd), .stall(stall),
        .rd(rd), .wData(wData), .regWr(regWr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: MDU buffer as a queue, scoreboard as a bit array.
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    bit [31:0]   pend;
    int          starve;
    logic        exp_regwr;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wd;
    bit          regs_known = 0;
    bit          addr_chk   = 0;
    logic [4:0]  wlog[$];

    always @(negedge clk) begin : model
        logic       e_ready, e_hold, e_stall, win;
        logic [4:0] wrd;
        logic [31:0] wd;
        if (!rst && regWr) wlog.push_back(rd);
        if (regs_known) begin
            chk("m_regWr", regWr, exp_regwr);
            if (addr_chk) begin
                chk("m_rd", rd, exp_rd);
                chk("m_wData", wData, exp_wd);
            end
        end
        if (rst) begin
            chk("m_rst_mduReady", mduReady, 1);
            chk("m_rst_aluHold", aluHold, 0);
            chk("m_rst_stall", stall, 0);
            q.delete();
            pend = '0;
            starve = 0;
            exp_regwr = 0;
            exp_rd = 0;
            exp_wd = 0;
            addr_chk = 1;
            regs_known = 1;
        end else if (regs_known) begin
            e_ready = (q.size() < 2);
            e_hold  = (q.size() > 0) && (starve == SM);
            e_stall = (rs1 != 0 && pend[rs1]) || (rs2 != 0 && pend[rs2]) || (idRd != 0 && pend[idRd]);
            chk("m_mduReady", mduReady, e_ready);
            chk("m_aluHold", aluHold, e_hold);
            chk("m_stall", stall, e_stall);
            win = 0;
            wrd = 0;
            wd  = 0;
            if (aluValid && !e_hold) begin
                win = 1;
                wrd = aluRd;
                wd  = aluData;
                starve = (q.size() > 0) ? starve + 1 : 0;
            end else if (q.size() > 0) begin
                win = 1;
                wrd = q[0].r;
                wd  = q[0].d;
                void'(q.pop_front());
                starve = 0;
                pend[wrd] = 1'b0;
            end else begin
                starve = 0;
            end
            if (issueMdu && issueRd != 0) pend[issueRd] = 1'b1;
            if (mduValid && e_ready) q.push_back('{mduRd, mduData});
            exp_regwr = win && (wrd != 0);
            addr_chk  = exp_regwr;
            if (exp_regwr) begin
                exp_rd = wrd;
                exp_wd = wd;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        aluValid = 0; aluRd = 0; aluData = 0;
        mduValid = 0; mduRd = 0; mduData = 0;
        issueMdu = 0; issueRd = 0;
        rs1 = 0; rs2 = 0; idRd = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, m, holds, hold_at, first_nr, mark;
        logic h, r;
        logic [4:0] exp_d [8];
        logic [4:0] exp_e [16];

        // Reset with garbage requests that must be discarded.
        rst = 1;
        aluValid = 1; aluRd = 4; aluData = 32'h1111_1111;
        mduValid = 1; mduRd = 3; mduData = 32'h3333_3333;
        issueMdu = 1; issueRd = 3;
        rs1 = 3; rs2 = 0; idRd = 0;
        #1;
        chk("rst_mduReady", mduReady, 1);
        chk("rst_aluHold", aluHold, 0);
        chk("rst_stall", stall, 0);
        step();
        step();
        chk("rst_regWr", regWr, 0);
        chk("rst_rd", rd, 0);
        chk("rst_wData", wData, 0);
        rst = 0;
        idle_inputs();
        rs1 = 3;
        step();
        chk("post_rst_stall_r3", stall, 0);
        chk("post_rst_regWr", regWr, 0);
        chk("post_rst_mduReady", mduReady, 1);
        rs1 = 0;

        // Single ALU write, latency 1.
        aluValid = 1; aluRd = 5; aluData = 32'hDEAD_BEEF;
        step();
        aluValid = 0;
        chk("alu_regWr", regWr, 1);
        chk("alu_rd", rd, 5);
        chk("alu_wData", wData, 32'hDEAD_BEEF);
        step();
        chk("alu_regWr_once", regWr, 0);

        // Scoreboard hazard on r7.
        issueMdu = 1; issueRd = 7;
        step();
        issueMdu = 0; rs1 = 7;
        #1;
        chk("stall_r7_set", stall, 1);
        step();
        step();
        chk("stall_r7_held", stall, 1);
        mduValid = 1; mduRd = 7; mduData = 32'h0000_0777;
        step();
        mduValid = 0;
        #1;
        chk("stall_r7_until_win", stall, 1);
        mark = wlog.size();
        step();
        chk("r7_regWr", regWr, 1);
        chk("r7_rd", rd, 7);
        chk("r7_wData", wData, 32'h0000_0777);
        chk("stall_r7_clear", stall, 0);
        step();
        chk("r7_regWr_once", regWr, 0);
        step();
        chk("r7_write_count", wlog.size() - mark, 1);
        rs1 = 0;

        // Starvation guard with one queued MDU result.
        exp_d = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd9, 5'd15, 5'd16};
        mark = wlog.size();
        k = 0; holds = 0; hold_at = -1;
        for (int c = 0; c < 8; c++) begin
            aluValid = 1; aluRd = 5'(10 + k); aluData = 32'hA000_0000 + k;
            mduValid = (c == 0); mduRd = 9; mduData = 32'h0000_0099;
            #1;
            h = aluHold;
            if (h) begin
                holds++;
                hold_at = c;
            end
            step();
            if (!h) k++;
        end
        idle_inputs();
        step();
        step();
        chk("starve_hold_count", holds, 1);
        chk("starve_hold_cycle", hold_at, 5);
        chk("starve_write_count", wlog.size() - mark, 8);
        for (int i = 0; i < 8; i++) begin
            if (mark + i < wlog.size()) chk("starve_order", wlog[mark + i], exp_d[i]);
        end

        // Three MDU results while ALU is busy: backpressure and arrival order.
        exp_e = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd24, 5'd6, 5'd7,
                  5'd8, 5'd9, 5'd25, 5'd10, 5'd11, 5'd12, 5'd13, 5'd26};
        mark = wlog.size();
        k = 0; m = 0; first_nr = -1;
        for (int c = 0; c < 16; c++) begin
            aluValid = 1; aluRd = 5'(1 + k); aluData = 32'hB000_0000 + k;
            mduValid = (m < 3); mduRd = 5'(24 + m); mduData = 32'hD000_0000 + m;
            #1;
            h = aluHold;
            r = mduReady;
            if (!r && first_nr < 0) first_nr = c;
            step();
            if (!h) k++;
            if (mduValid && r) m++;
        end
        idle_inputs();
        step();
        step();
        step();
        chk("bp_first_not_ready", first_nr, 2);
        chk("bp_all_accepted", m, 3);
        chk("bp_write_count", wlog.size() - mark, 16);
        for (int i = 0; i < 16; i++) begin
            if (mark + i < wlog.size()) chk("bp_order", wlog[mark + i], exp_e[i]);
        end

        // Destination 0: consumed silently, never stalls.
        mark = wlog.size();
        mduValid = 1; mduRd = 0; mduData = 32'h0000_1234;
        step();
        mduValid = 0;
        issueMdu = 1; issueRd = 0;
        step();
        issueMdu = 0;
        chk("rd0_regWr", regWr, 0);
        chk("rd0_stall", stall, 0);
        step();
        chk("rd0_no_write", wlog.size() - mark, 0);
        chk("rd0_consumed", mduReady, 1);

        // Reset with a full buffer and pending bits.
        issueMdu = 1; issueRd = 12;
        step();
        issueRd = 13;
        step();
        issueMdu = 0; rs1 = 12; rs2 = 13;
        aluValid = 1; aluRd = 3; aluData = 32'hC0C0_0003;
        mduValid = 1; mduRd = 12; mduData = 32'hC000_0012;
        step();
        mduRd = 13; mduData = 32'hC000_0013;
        step();
        mduValid = 0;
        #1;
        chk("pre_rst_full", mduReady, 0);
        chk("pre_rst_stall", stall, 1);
        rst = 1; aluValid = 0;
        step();
        rst = 0;
        mark = wlog.size();
        chk("mid_rst_regWr", regWr, 0);
        chk("mid_rst_mduReady", mduReady, 1);
        chk("mid_rst_stall", stall, 0);
        step();
        step();
        step();
        step();
        chk("mid_rst_no_write", wlog.size() - mark, 0);

        idle_inputs();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
